fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of one fifo instance between NUM_REQ producers.
//  Grants one requester at a time for a burst of up to BURST words.
//  Steers that requester's data onto the fifo write port and returns a per-word accept (ack).
//  Honours fifo full backpressure, so no write is ever issued into a full fifo.
// PARAMETERS
//  WIDTH    8  data word width; equals the fifo WIDTH
//  NUM_REQ  4  number of requesters, 2..16
//  BURST    4  max words accepted per grant, >=1
//  IDX_W    2  requester index width, = clog2(NUM_REQ)
// PORTS
//  clock           in   1              system clock, all state on posedge
//  reset           in   1              synchronous, active-high reset
//  req             in   NUM_REQ        per-requester "word available"; held until acked
//  req_data        in   NUM_REQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//  req_ack         out  NUM_REQ        one-hot; word of requester i taken this cycle
//  fifo_full       in   1              full flag from the fifo
//  fifo_write_enb  out  1              fifo write enable
//  fifo_data_in    out  WIDTH          fifo write data
//  grant           out  NUM_REQ        one-hot registered owner; 0 when idle
//  grant_idx       out  IDX_W          index of owner; valid when busy=1
//  busy            out  1              1 while in XFER
// BEHAVIOUR
//  Reset: all of the following take effect at the next posedge, with no partial burst retained.
//   - state=IDLE, grant=0, grant_idx=0, busy=0, beat count=0.
//   - Round-robin pointer last=NUM_REQ-1, so req[0] has priority first.
//   - req_ack=0 and fifo_write_enb=0.
//  FSM has two states, IDLE and XFER.
//  IDLE:
//   - If req!=0, select the first set bit searching last+1, last+2, ... (mod NUM_REQ).
//   - Register grant/grant_idx, set last=selected, clear count, go to XFER.
//   - No write in IDLE; arbitration costs exactly 1 cycle.
//  XFER, combinational write path:
//   - fifo_write_enb = req[grant_idx] & ~fifo_full.
//   - fifo_data_in = req_data slice grant_idx.
//   - req_ack = grant & {NUM_REQ{fifo_write_enb}}.
//   - Zero-cycle latency from req to write when the fifo is not full.
//  XFER, exit conditions:
//   - Each accepted word increments count.
//   - Go to IDLE (grant=0, busy=0) when the word is accepted with count==BURST-1.
//   - Go to IDLE when req[grant_idx]==0; no write that cycle.
//   - fifo_full=1 with req held: stay in XFER, count held, no ack, no write (stall, grant kept).
//   - Otherwise stay in XFER.
//  fifo_data_in when fifo_write_enb=0:
//   - Don't care.
//   - Drive the granted slice (IDLE: slice 0) so the value is deterministic.
//  Fairness:
//   - A requester holding req is granted within NUM_REQ-1 other bursts.
//   - Non-granted req changes are ignored until the next IDLE.
//  Simultaneous last-word accept and a new req from any source: always IDLE for 1 cycle, then arbitrate.
//  count width: clog2(BURST)+1 bits; no wrap inside a burst.
//  Requester contract: req_data stable while req=1 and not acked. Violation is not detected.
// TESTING
//  1. NUM_REQ=4, BURST=4; only req[0]=1 with 6 words 0x10..0x15, fifo empty.
//     -> writes 0x10-0x13 on 4 consecutive cycles, 1 IDLE cycle, then 0x14-0x15, then IDLE.
//  2. req=4'b1111 held, fifo never full.
//     -> grant order 0,1,2,3,0 with 4 writes each and 1 idle cycle between bursts.
//  3. req[2] streaming; fifo_full=1 for 3 cycles after the 2nd word.
//     -> no write/ack for those 3 cycles, grant stays 4'b0100, then words 3-4 written, burst ends.
//  4. req[1] drops after 2 accepted words.
//     -> IDLE the next cycle; req[3] pending gets the next grant (search from 2).
//  5. reset=1 mid-burst with 2 words done.
//     -> next cycle grant=0, busy=0, no write; after release, req[0] wins over req[3].
//  6. Scoreboard: random req/fifo_full for 10k cycles against the fifo model.
//     -> no write while full, per-requester order kept, no requester starved >3 bursts.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Brief    : Requester-side and fifo-side signals of the write-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ack;
   logic                     fifo_full;
   logic                     fifo_write_enb;
   logic [WIDTH-1:0]         fifo_data_in;
   logic [NUM_REQ-1:0]       grant;
   logic [IDX_W-1:0]         grant_idx;
   logic                     busy;

   modport master (
      input  req, req_data, fifo_full,
      output req_ack, fifo_write_enb, fifo_data_in, grant, grant_idx, busy
   );

   modport slave (
      output req, req_data, fifo_full,
      input  req_ack, fifo_write_enb, fifo_data_in, grant, grant_idx, busy
   );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Round-robin, burst-limited sharing of one fifo write port.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4,
   parameter int BURST   = 4,
   parameter int IDX_W   = 2
) (
   input  wire logic          clock,
   input  wire logic          reset,
   fifo_wr_arbiter_if.master  bus
);
   localparam int                 c_CNT_W     = $clog2(BURST) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BURST - 1);
   localparam logic [IDX_W-1:0]   c_IDX_LAST  = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]     c_NUM       = (IDX_W + 1)'(NUM_REQ);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_nxt;
   logic [IDX_W-1:0]   r_last, w_last_nxt;
   logic [c_CNT_W-1:0] r_count, w_count_nxt;
   logic [IDX_W-1:0]   w_sel_idx;
   logic [IDX_W-1:0]   w_slice_idx;
   logic [IDX_W:0]     w_cand;
   logic               w_found;
   logic               w_owner_req;
   logic               w_wr_en;
   logic [WIDTH-1:0]   w_words [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_words[gi] = bus.req_data[gi*WIDTH +: WIDTH];
   end

   // Rotating priority search starting just after the previous owner.
   always_comb begin
      w_found   = 1'b0;
      w_sel_idx = '0;
      w_cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = {1'b0, r_last} + (IDX_W + 1)'(k);
         if (w_cand >= c_NUM) begin
            w_cand = w_cand - c_NUM;
         end
         if (!w_found && bus.req[w_cand[IDX_W-1:0]]) begin
            w_found   = 1'b1;
            w_sel_idx = w_cand[IDX_W-1:0];
         end
      end
   end

   assign w_owner_req = bus.req[r_grant_idx];
   assign w_wr_en     = (r_state == ST_XFER) && w_owner_req && !bus.fifo_full;
   assign w_slice_idx = (r_state == ST_XFER) ? r_grant_idx : '0;

   assign bus.fifo_write_enb = w_wr_en;
   assign bus.fifo_data_in   = w_words[w_slice_idx];
   assign bus.req_ack        = r_grant & {NUM_REQ{w_wr_en}};
   assign bus.grant          = r_grant;
   assign bus.grant_idx      = r_grant_idx;
   assign bus.busy           = (r_state == ST_XFER);

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_grant_idx_nxt = r_grant_idx;
      w_last_nxt      = r_last;
      w_count_nxt     = r_count;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt            = ST_XFER;
               w_grant_nxt            = '0;
               w_grant_nxt[w_sel_idx] = 1'b1;
               w_grant_idx_nxt        = w_sel_idx;
               w_last_nxt             = w_sel_idx;
               w_count_nxt            = '0;
            end
         end
         ST_XFER: begin
            // A withdrawn request or the final beat of a burst both end the grant.
            if (!w_owner_req || (w_wr_en && (r_count == c_LAST_BEAT))) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
               w_count_nxt = '0;
            end else if (w_wr_en) begin
               w_count_nxt = r_count + c_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_last      <= c_IDX_LAST;
         r_count     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_grant_idx_nxt;
         r_last      <= w_last_nxt;
         r_count     <= w_count_nxt;
      end
   end
endmodule
`default_nettype wire
